uart_cmd_parser: RTL and testbench

//  Byte-level command decoder between the UART receiver/transmitter and the DDS core internals.

---
 rtl/dds_cmd_pkg.sv | 25 ++
 rtl/uart_cmd_parser_if.sv | 36 +++
 rtl/cmd_timeout_cnt.sv | 29 ++
 rtl/uart_cmd_parser.sv | 151 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_cmd_pkg.sv
// rtl/dds_cmd_pkg.sv - opcodes and parser state type shared by the UART command parser
package dds_cmd_pkg;

    localparam logic [7:0] CMD_NOP  = 8'h00;
    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] CMD_LOAD = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_RD_CAP,
        ST_RD_SEND,
        ST_TX_WAIT,
        ST_LOAD
    } parser_state_t;

    // States that wait on the host for another byte; only these can time out.
    function automatic logic timeout_armed(parser_state_t s);
        return (s == ST_WR_ADDR) || (s == ST_WR_DATA) || (s == ST_RD_ADDR) || (s == ST_LOAD);
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - UART, register-file and waveform-RAM signals of the command parser
// master: the parser (consumes rx bytes / tx_done / reg_rdata, drives everything else)
// slave : the surrounding UART, register file and waveform RAM
interface uart_cmd_parser_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
);
    logic [7:0]            rx_data;
    logic                  rx_done;
    logic [7:0]            tx_data;
    logic                  tx_wr;
    logic                  tx_done;
    logic [7:0]            reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic                  reg_wr;
    logic                  reg_rd;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic [ADDR_WIDTH-1:0] wav_addr;
    logic [DATA_WIDTH-1:0] wav_wdata;
    logic                  wav_we;
    logic                  load_busy;
    logic                  load_done;
    logic                  cmd_err;

    modport master (
        input  rx_data, rx_done, tx_done, reg_rdata,
        output tx_data, tx_wr, reg_addr, reg_wdata, reg_wr, reg_rd,
               wav_addr, wav_wdata, wav_we, load_busy, load_done, cmd_err
    );

    modport slave (
        output rx_data, rx_done, tx_done, reg_rdata,
        input  tx_data, tx_wr, reg_addr, reg_wdata, reg_wr, reg_rd,
               wav_addr, wav_wdata, wav_we, load_busy, load_done, cmd_err
    );
endinterface

// File: rtl/cmd_timeout_cnt.sv
// rtl/cmd_timeout_cnt.sv - inter-byte idle timer that aborts a stalled partial command
// Ports: clk, rst (sync active-high), clear (restart count), enable (count while high),
//        expire (combinational pulse on the TIMEOUT_CYCLES-th consecutive idle enabled cycle)
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 104167
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;
    logic          hit;

    assign hit    = (count == CW'(TIMEOUT_CYCLES - 1));
    // A clear in the same cycle wins: a byte arriving just in time is not aborted.
    assign expire = enable && !clear && hit;

    always_ff @(posedge clk) begin
        if (rst || clear || !enable || hit) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - byte-level NOP/WR/RD/LOAD command decoder for the DDS core
// Ports: clk, rst (sync active-high), bus (uart_cmd_parser_if.master):
//        rx_data/rx_done in, tx_data/tx_wr out, tx_done in,
//        reg_addr/reg_wdata/reg_wr/reg_rd out, reg_rdata in,
//        wav_addr/wav_wdata/wav_we out, load_busy/load_done/cmd_err out
module uart_cmd_parser
    import dds_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 256,
    parameter int TIMEOUT_CYCLES = 104167
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_parser_if.master  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    parser_state_t    state;
    logic [CNT_W-1:0] load_cnt;
    logic             tmo_expire;

    cmd_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.rx_done),
        .enable (timeout_armed(state)),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            load_cnt      <= '0;
            bus.tx_data   <= '0;
            bus.tx_wr     <= 1'b0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.reg_wr    <= 1'b0;
            bus.reg_rd    <= 1'b0;
            bus.wav_addr  <= '0;
            bus.wav_wdata <= '0;
            bus.wav_we    <= 1'b0;
            bus.load_busy <= 1'b0;
            bus.load_done <= 1'b0;
            bus.cmd_err   <= 1'b0;
        end else begin
            bus.tx_wr     <= 1'b0;
            bus.reg_wr    <= 1'b0;
            bus.reg_rd    <= 1'b0;
            bus.wav_we    <= 1'b0;
            bus.load_done <= 1'b0;
            bus.cmd_err   <= 1'b0;

            // Address advances after each sample is written; the final write
            // leaves it on DEPTH-1 so it never wraps.
            if (bus.wav_we && !bus.load_done) begin
                bus.wav_addr <= bus.wav_addr + ADDR_WIDTH'(1);
            end
            if (bus.load_done) begin
                bus.load_busy <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.rx_done) begin
                        case (bus.rx_data)
                            CMD_NOP:  ;
                            CMD_WR:   state <= ST_WR_ADDR;
                            CMD_RD:   state <= ST_RD_ADDR;
                            CMD_LOAD: begin
                                state         <= ST_LOAD;
                                load_cnt      <= '0;
                                bus.wav_addr  <= '0;
                                bus.load_busy <= 1'b1;
                            end
                            default:  bus.cmd_err <= 1'b1;
                        endcase
                    end
                end
                ST_WR_ADDR: begin
                    if (bus.rx_done) begin
                        bus.reg_addr <= bus.rx_data;
                        state        <= ST_WR_DATA;
                    end else if (tmo_expire) begin
                        bus.cmd_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_WR_DATA: begin
                    if (bus.rx_done) begin
                        bus.reg_wdata <= DATA_WIDTH'(bus.rx_data);
                        bus.reg_wr    <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (tmo_expire) begin
                        bus.cmd_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_RD_ADDR: begin
                    if (bus.rx_done) begin
                        bus.reg_addr <= bus.rx_data;
                        bus.reg_rd   <= 1'b1;
                        state        <= ST_RD_CAP;
                    end else if (tmo_expire) begin
                        bus.cmd_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_RD_CAP: begin
                    bus.cmd_err <= bus.rx_done;
                    // reg_rdata is valid the cycle after the read strobe.
                    if (!bus.reg_rd) begin
                        bus.tx_data <= bus.reg_rdata[7:0];
                        state       <= ST_RD_SEND;
                    end
                end
                ST_RD_SEND: begin
                    bus.cmd_err <= bus.rx_done;
                    bus.tx_wr   <= 1'b1;
                    state       <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    bus.cmd_err <= bus.rx_done;
                    if (bus.tx_done) begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (bus.rx_done) begin
                        bus.wav_wdata <= DATA_WIDTH'(bus.rx_data);
                        bus.wav_we    <= 1'b1;
                        load_cnt      <= load_cnt + CNT_W'(1);
                        if (load_cnt == CNT_W'(DEPTH - 1)) begin
                            bus.load_done <= 1'b1;
                            state         <= ST_IDLE;
                        end
                    end else if (tmo_expire) begin
                        bus.cmd_err   <= 1'b1;
                        bus.load_busy <= 1'b0;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed scoreboard bench for uart_cmd_parser
module tb_uart_cmd_parser;
    localparam int AW  = 9;
    localparam int DW  = 8;
    localparam int DEP = 256;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rdata_q = 8'h00;

    int checks = 0;
    int errors = 0;
    int n_wr = 0, n_rd = 0, n_tx = 0, n_we = 0, n_done = 0, n_err = 0;

    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [16:0] exp_wav[$];
    logic [15:0] mon_e16;
    logic [16:0] mon_e17;

    always #5 clk = ~clk;

    uart_cmd_parser_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    uart_cmd_parser #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register file read port: data appears the cycle after reg_rd, zero otherwise.
    always @(posedge clk) rdata_q <= bus.reg_rd ? (bus.reg_addr ^ 8'h04) : 8'h00;
    assign bus.reg_rdata = rdata_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    function automatic logic [7:0] cos_sample(input int i);
        real r;
        r = 127.0 * $cos(2.0 * 3.14159265358979 * i / 256.0);
        return 8'($rtoi(r));
    endfunction

    always @(negedge clk) begin
        if (bus.reg_wr) begin
            n_wr++;
            if (exp_wr.size() == 0) check("reg_wr_unexpected", 32'd1, 32'd0);
            else begin
                mon_e16 = exp_wr.pop_front();
                check("reg_wr_addr", 32'(bus.reg_addr), 32'(mon_e16[15:8]));
                check("reg_wr_data", 32'(bus.reg_wdata), 32'(mon_e16[7:0]));
            end
        end
        if (bus.reg_rd) begin
            n_rd++;
            if (exp_rd.size() == 0) check("reg_rd_unexpected", 32'd1, 32'd0);
            else check("reg_rd_addr", 32'(bus.reg_addr), 32'(exp_rd.pop_front()));
        end
        if (bus.tx_wr) begin
            n_tx++;
            if (exp_tx.size() == 0) check("tx_wr_unexpected", 32'd1, 32'd0);
            else check("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
        end
        if (bus.wav_we) begin
            n_we++;
            if (exp_wav.size() == 0) check("wav_we_unexpected", 32'd1, 32'd0);
            else begin
                mon_e17 = exp_wav.pop_front();
                check("wav_addr", 32'(bus.wav_addr), 32'(mon_e17[16:8]));
                check("wav_wdata", 32'(bus.wav_wdata), 32'(mon_e17[7:0]));
                check("load_done_on_we", 32'(bus.load_done), 32'(mon_e17[16:8] == 9'(DEP - 1)));
            end
        end
        if (bus.load_done) n_done++;
        if (bus.cmd_err) n_err++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_wr, b_rd, b_tx, b_we, b_done, b_err;
        logic found;

        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.tx_done = 1'b0;
        rst = 1'b1;
        gap(3);
        rst = 1'b0;
        check("rst_outputs", 32'({bus.tx_wr, bus.reg_wr, bus.reg_rd, bus.wav_we,
                                  bus.load_busy, bus.load_done, bus.cmd_err}), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
        check("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        check("rst_wav_addr", 32'(bus.wav_addr), 32'd0);
        check("rst_wav_wdata", 32'(bus.wav_wdata), 32'd0);
        gap(2);

        // WR 01 03 0E
        b_wr = n_wr; b_err = n_err;
        exp_wr.push_back(16'h030E);
        send_byte(8'h01); gap(3);
        send_byte(8'h03); gap(3);
        send_byte(8'h0E);
        check("wr_latency", 32'(bus.reg_wr), 32'd1);
        tick();
        check("wr_single_cycle", 32'(bus.reg_wr), 32'd0);
        gap(3);
        check("wr_count", 32'(n_wr - b_wr), 32'd1);
        check("wr_no_err", 32'(n_err - b_err), 32'd0);

        // RD 02 01, register returns 05
        b_rd = n_rd; b_tx = n_tx; b_err = n_err;
        exp_rd.push_back(8'h01);
        exp_tx.push_back(8'h05);
        send_byte(8'h02); gap(3);
        send_byte(8'h01);
        check("rd_latency", 32'(bus.reg_rd), 32'd1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (bus.tx_wr) found = 1'b1;
            else tick();
        end
        check("tx_wr_seen", 32'(found), 32'd1);
        gap(3);
        send_byte(8'h00);
        check("tx_wait_byte_dropped", 32'(bus.cmd_err), 32'd1);
        gap(2);
        bus.tx_done = 1'b1;
        tick();
        bus.tx_done = 1'b0;
        gap(2);
        send_byte(8'h00);
        gap(3);
        check("rd_reg_rd_count", 32'(n_rd - b_rd), 32'd1);
        check("rd_tx_count", 32'(n_tx - b_tx), 32'd1);
        check("rd_err_count", 32'(n_err - b_err), 32'd1);

        // LOAD full cosine table
        b_we = n_we; b_done = n_done;
        send_byte(8'h03);
        check("load_busy_set", 32'(bus.load_busy), 32'd1);
        gap(2);
        for (int i = 0; i < DEP; i++) begin
            exp_wav.push_back({9'(i), cos_sample(i)});
            send_byte(cos_sample(i));
            if (i == 0) check("load_first_we", 32'({bus.wav_we, bus.wav_addr}), 32'({1'b1, 9'd0}));
            if (i == DEP - 1) begin
                check("load_done_last", 32'({bus.wav_we, bus.load_done}), 32'd3);
                tick();
                check("load_busy_clear", 32'(bus.load_busy), 32'd0);
            end
            gap(2);
        end
        check("load_we_count", 32'(n_we - b_we), 32'(DEP));
        check("load_done_count", 32'(n_done - b_done), 32'd1);

        // Timeout after 01 00, then a clean 01 00 01
        b_wr = n_wr; b_err = n_err;
        send_byte(8'h01); gap(3);
        send_byte(8'h00);
        gap(TMO + 20);
        check("timeout_err", 32'(n_err - b_err), 32'd1);
        check("timeout_no_wr", 32'(n_wr - b_wr), 32'd0);
        exp_wr.push_back(16'h0001);
        send_byte(8'h01); gap(3);
        send_byte(8'h00); gap(3);
        send_byte(8'h01);
        check("post_timeout_wr", 32'(bus.reg_wr), 32'd1);
        gap(3);
        check("post_timeout_wr_count", 32'(n_wr - b_wr), 32'd1);

        // Bad opcode then NOP
        b_wr = n_wr; b_rd = n_rd; b_tx = n_tx; b_we = n_we; b_err = n_err;
        send_byte(8'h7F);
        check("bad_op_err", 32'(bus.cmd_err), 32'd1);
        gap(3);
        send_byte(8'h00);
        gap(5);
        check("bad_op_err_count", 32'(n_err - b_err), 32'd1);
        check("bad_op_no_strobes", 32'((n_wr - b_wr) + (n_rd - b_rd) + (n_tx - b_tx) + (n_we - b_we)), 32'd0);

        // Reset in the middle of a LOAD, then a full LOAD
        b_done = n_done; b_we = n_we;
        send_byte(8'h03); gap(2);
        for (int i = 0; i < 100; i++) begin
            exp_wav.push_back({9'(i), 8'(i * 3)});
            send_byte(8'(i * 3));
            gap(2);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_load_busy", 32'(bus.load_busy), 32'd0);
        check("rst_mid_load_addr", 32'(bus.wav_addr), 32'd0);
        gap(3);
        check("rst_mid_load_no_done", 32'(n_done - b_done), 32'd0);
        send_byte(8'h03); gap(2);
        for (int i = 0; i < DEP; i++) begin
            exp_wav.push_back({9'(i), 8'(i) ^ 8'h5A});
            send_byte(8'(i) ^ 8'h5A);
            if (i == 0) check("reload_first_addr", 32'({bus.wav_we, bus.wav_addr}), 32'({1'b1, 9'd0}));
            gap(2);
        end
        gap(2);
        check("reload_we_count", 32'(n_we - b_we), 32'(100 + DEP));
        check("reload_done_count", 32'(n_done - b_done), 32'd1);
        check("reload_busy_low", 32'(bus.load_busy), 32'd0);

        check("sb_empty", 32'(exp_wr.size() + exp_rd.size() + exp_tx.size() + exp_wav.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
